// File: rtl/binary_decoder_seq_if.sv
// Bus bundle for binary_decoder_seq: enable, code handshake, decoded output,
// accept counter and the FSM state for observation.
// Handshake: a code transfers on the rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on FSM state, en and reset,
// never on in_valid. The source holds code_in steady until that edge.
interface binary_decoder_seq_if #(
  parameter int IN_W = 2
) ();
  localparam int OUT_W = 2 ** IN_W;

  logic             en;
  logic [IN_W-1:0]  code_in;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] dec_out;
  logic             out_valid;
  logic [7:0]       dec_count;
  logic [1:0]       dbg_state;

  modport slave (
    input  en, code_in, in_valid,
    output in_ready, dec_out, out_valid, dec_count, dbg_state
  );

  modport master (
    output en, code_in, in_valid,
    input  in_ready, dec_out, out_valid, dec_count, dbg_state
  );
endinterface

// File: rtl/binary_decoder_seq.sv
// Registered, handshaked N-to-2^N binary decoder. An accepted code is shown
// as a one-hot word for HOLD_CYCLES cycles, followed by GAP_CYCLES cycles of
// all-zero output, before the next code can be accepted. Dropping en while
// busy aborts back to IDLE.
module binary_decoder_seq #(
  parameter int IN_W        = 2,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_decoder_seq_if.slave  bus
);
  localparam int OUT_W = 2 ** IN_W;

  // Counter reload values; the counter counts down to zero inside a phase.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             valid_q, valid_d;
  logic [7:0]       count_q, count_d;
  logic             ready;
  logic             accept;

  // Ready is forced low during reset even though state already reads IDLE.
  assign ready  = rst_n && bus.en && (state_q == ST_IDLE);
  assign accept = ready && bus.in_valid;

  // Next-state and next-output logic for the IDLE / HOLD / GAP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        dec_d   = '0;
        valid_d = 1'b0;
        if (accept) begin
          state_d = ST_HOLD;
          dec_d   = {{(OUT_W-1){1'b0}}, 1'b1} << bus.code_in;
          valid_d = 1'b1;
          cnt_d   = HOLD_LOAD;
          count_d = count_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!bus.en) begin
          state_d = ST_IDLE;
          dec_d   = '0;
          valid_d = 1'b0;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          dec_d   = '0;
          valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end
      end
      ST_GAP: begin
        dec_d   = '0;
        valid_d = 1'b0;
        if (!bus.en) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dec_d   = '0;
        valid_d = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      dec_q   <= '0;
      valid_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.dec_out   = dec_q;
  assign bus.out_valid = valid_q;
  assign bus.dec_count = count_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_binary_decoder_seq.sv
// Bench for binary_decoder_seq: default build (HOLD=3, GAP=1) plus a
// HOLD=1, GAP=0 build sharing clock and reset.
module tb_binary_decoder_seq;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  binary_decoder_seq_if #(.IN_W(2)) bus ();
  binary_decoder_seq_if #(.IN_W(2)) bus2 ();

  binary_decoder_seq #(.IN_W(2), .HOLD_CYCLES(3), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  binary_decoder_seq #(.IN_W(2), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] exp_q[$];
  logic [7:0] exp_count;
  logic       prev_valid = 1'b0;

  function automatic logic [3:0] onehot(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20; k++) begin
      if (bus.in_ready === 1'b1) break;
      tick();
    end
    if (k == 20) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard push: every handshake of the default build queues its one-hot.
  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(onehot(int'(bus.code_in)));
  end

  // Scoreboard pop on each new output word; idle output must be all zeros.
  always @(negedge clk) begin
    if (bus.out_valid && !prev_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'(bus.dec_out), 32'd0);
      else chk("sb_dec_out", 32'(bus.dec_out), 32'(exp_q.pop_front()));
    end else if (!bus.out_valid) begin
      chk("idle_zero", 32'(bus.dec_out), 32'd0);
    end
    prev_valid = bus.out_valid;
  end

  // Directed sequence.
  initial begin
    int acc_cyc[4];
    rst_n = 1'b0;
    bus.en = 1'b1; bus.in_valid = 1'b0; bus.code_in = '0;
    bus2.en = 1'b1; bus2.in_valid = 1'b0; bus2.code_in = '0;
    exp_count = 8'd0;

    // Reset state.
    #2;
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_dec", 32'(bus.dec_out), 32'd0);
    chk("rst_count", 32'(bus.dec_count), 32'd0);
    #20 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));

    // Single code 2: three hold cycles, one gap cycle, then ready again.
    bus.code_in = 2'd2; bus.in_valid = 1'b1;
    tick();
    exp_count++;
    bus.in_valid = 1'b0; bus.code_in = 2'd1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_hold_dec", 32'(bus.dec_out), 32'h4);
      chk("t1_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_hold_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    chk("t1_gap_dec", 32'(bus.dec_out), 32'd0);
    chk("t1_gap_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_gap_state", 32'(bus.dbg_state), 32'(S_GAP));
    chk("t1_gap_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("t1_ready_back", 32'(bus.in_ready), 32'd1);
    chk("t1_count", 32'(bus.dec_count), 32'(exp_count));

    // Sweep codes 0..3 with in_valid held high.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.code_in = 2'(i);
      wait_ready();
      tick();
      acc_cyc[i] = cyc;
      exp_count++;
    end
    bus.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("sweep_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd5);
    chk("sweep_count", 32'(bus.dec_count), 32'(exp_count));
    wait_ready();

    // en dropped in the second hold cycle of code 3.
    bus.code_in = 2'd3; bus.in_valid = 1'b1;
    tick();
    exp_count++;
    bus.in_valid = 1'b0;
    tick();
    chk("abort_pre_dec", 32'(bus.dec_out), 32'h8);
    bus.en = 1'b0;
    tick();
    chk("abort_dec", 32'(bus.dec_out), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_state", 32'(bus.dbg_state), 32'(S_IDLE));
    chk("abort_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    tick(); tick();
    chk("en_low_ready", 32'(bus.in_ready), 32'd0);
    chk("en_low_count", 32'(bus.dec_count), 32'(exp_count));
    bus.in_valid = 1'b0;
    bus.en = 1'b1;
    #1;
    chk("en_back_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Asynchronous reset mid-hold.
    bus.code_in = 2'd1; bus.in_valid = 1'b1;
    wait_ready();
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dec", 32'(bus.dec_out), 32'd0);
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_count", 32'(bus.dec_count), 32'd0);
    chk("async_rst_ready", 32'(bus.in_ready), 32'd0);
    exp_count = 8'd0;
    #1 rst_n = 1'b1;
    tick();
    bus.code_in = 2'd0; bus.in_valid = 1'b1;
    wait_ready();
    tick();
    exp_count++;
    bus.in_valid = 1'b0;
    chk("post_rst_accept_dec", 32'(bus.dec_out), 32'h1);
    chk("post_rst_accept_count", 32'(bus.dec_count), 32'(exp_count));

    // Accept until the counter wraps past 255.
    bus.in_valid = 1'b1;
    for (int n = 0; n < 255; n++) begin
      bus.code_in = 2'($urandom_range(0, 3));
      wait_ready();
      tick();
      exp_count++;
      if (n == 253) chk("count_255", 32'(bus.dec_count), 32'd255);
    end
    bus.in_valid = 1'b0;
    chk("count_wrap", 32'(bus.dec_count), 32'd0);
    chk("count_model", 32'(bus.dec_count), 32'(exp_count));
    wait_ready();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // HOLD=1, GAP=0 build: continuous in_valid gives one accept every 2 cycles.
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.code_in = 2'(i);
      chk("b2_ready", 32'(bus2.in_ready), 32'd1);
      tick();
      chk("b2_dec", 32'(bus2.dec_out), 32'(onehot(i)));
      chk("b2_valid", 32'(bus2.out_valid), 32'd1);
      tick();
      chk("b2_zero", 32'(bus2.dec_out), 32'd0);
    end
    bus2.in_valid = 1'b0;
    chk("b2_count", 32'(bus2.dec_count), 32'd4);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule
